// File: rtl/tapasco_dm_pkg.sv
// rtl/tapasco_dm_pkg.sv - shared types and constants for the TaPaSCo DM AXI slave
package tapasco_dm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4
    } dm_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // WRAP and the reserved encoding both have burst[1] set
    function automatic logic req_error(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [5:0] atop, input logic [7:0] len,
                                       input logic burst_en);
        return burst[1] || (size > 3'd3) || (atop != 6'd0) || (!burst_en && (len != 8'd0));
    endfunction

endpackage

// File: rtl/tapasco_dm_axi_slave_if.sv
// rtl/tapasco_dm_axi_slave_if.sv - AXI4 channel bundle between interconnect and DM slave bridge
interface tapasco_dm_axi_slave_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 4
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [5:0]          awatop;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic [USER_W-1:0]   buser;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [USER_W-1:0]   ruser;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awatop, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awatop, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/tapasco_dm_axi_addr_gen.sv
// rtl/tapasco_dm_axi_addr_gen.sv - burst address and beat counter for the DM AXI slave
module tapasco_dm_axi_addr_gen
    import tapasco_dm_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_len,
    input  logic [2:0]        load_size,
    input  logic [1:0]        load_burst,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [7:0] cnt;
    logic [2:0] size_q;
    logic [1:0] burst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr    <= '0;
            cnt     <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else if (load) begin
            addr    <= load_addr;
            cnt     <= load_len;
            size_q  <= load_size;
            burst_q <= load_burst;
        end else if (advance) begin
            cnt <= cnt - 8'd1;
            // FIXED holds the address; INCR wraps naturally at the address width
            if (burst_q == BURST_INCR)
                addr <= addr + (ADDR_W'(1) << size_q);
        end
    end

    assign last = (cnt == 8'd0);

endmodule

// File: rtl/tapasco_dm_axi_slave.sv
// rtl/tapasco_dm_axi_slave.sv - AXI4 to DM slave-port bridge; TAPASCO_DM_AXI_BURST_EN enables len>0 bursts
module tapasco_dm_axi_slave
    import tapasco_dm_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    tapasco_dm_axi_slave_if.slave       axi,
    output logic                        slave_req_o,
    output logic                        slave_we_o,
    output logic [AXI_ADDR_WIDTH-1:0]   slave_addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0] slave_be_o,
    output logic [AXI_DATA_WIDTH-1:0]   slave_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]   slave_rdata_i
);
`ifdef TAPASCO_DM_AXI_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    dm_state_e                 state;
    logic                      last_was_write;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      err_q;
    logic                      rd_first;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic                      take_aw;
    logic                      take_ar;
    logic                      w_hs;
    logic                      r_hs;
    logic                      gen_last;
    logic                      gen_advance;
    logic [AXI_ADDR_WIDTH-1:0] gen_addr;

    // Ties go to whichever channel did not win the previous grant
    assign take_aw = (state == ST_IDLE) && axi.awvalid && (!axi.arvalid || !last_was_write);
    assign take_ar = (state == ST_IDLE) && axi.arvalid && !take_aw;
    assign w_hs    = (state == ST_WR_DATA) && axi.wvalid;
    assign r_hs    = (state == ST_RD_DATA) && axi.rready;
    assign gen_advance = w_hs || (r_hs && !gen_last);

    tapasco_dm_axi_addr_gen #(
        .ADDR_W (AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (take_aw || take_ar),
        .advance    (gen_advance),
        .load_addr  (take_aw ? axi.awaddr  : axi.araddr),
        .load_len   (take_aw ? axi.awlen   : axi.arlen),
        .load_size  (take_aw ? axi.awsize  : axi.arsize),
        .load_burst (take_aw ? axi.awburst : axi.arburst),
        .addr       (gen_addr),
        .last       (gen_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            last_was_write <= 1'b0;
            id_q           <= '0;
            err_q          <= 1'b0;
            rd_first       <= 1'b0;
            rdata_q        <= '0;
        end else begin
            rd_first <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_aw) begin
                        state          <= ST_WR_DATA;
                        id_q           <= axi.awid;
                        err_q          <= req_error(axi.awburst, axi.awsize, axi.awatop,
                                                    axi.awlen, BURST_EN);
                        last_was_write <= 1'b1;
                    end else if (take_ar) begin
                        state          <= ST_RD_REQ;
                        id_q           <= axi.arid;
                        err_q          <= req_error(axi.arburst, axi.arsize, 6'd0,
                                                    axi.arlen, BURST_EN);
                        last_was_write <= 1'b0;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs && axi.wlast)
                        state <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (axi.bready)
                        state <= ST_IDLE;
                end
                ST_RD_REQ: begin
                    state    <= ST_RD_DATA;
                    rd_first <= 1'b1;
                end
                ST_RD_DATA: begin
                    // DM read data is only valid the cycle after the strobe, so capture it once
                    if (rd_first)
                        rdata_q <= slave_rdata_i;
                    if (r_hs)
                        state <= gen_last ? ST_IDLE : ST_RD_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        slave_req_o   = 1'b0;
        slave_we_o    = 1'b0;
        slave_be_o    = '0;
        slave_wdata_o = '0;
        if (state == ST_WR_DATA) begin
            slave_req_o   = axi.wvalid && !err_q;
            slave_we_o    = 1'b1;
            slave_be_o    = axi.wstrb;
            slave_wdata_o = axi.wdata;
        end else if (state == ST_RD_REQ) begin
            slave_req_o = !err_q;
            slave_be_o  = {(AXI_DATA_WIDTH/8){1'b1}};
        end
    end

    assign slave_addr_o = {gen_addr[AXI_ADDR_WIDTH-1:3], 3'b000};

    assign axi.awready = take_aw;
    assign axi.arready = take_ar;
    assign axi.wready  = (state == ST_WR_DATA);

    assign axi.bvalid  = (state == ST_WR_RESP);
    assign axi.bid     = id_q;
    assign axi.bresp   = (state == ST_WR_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.buser   = {AXI_USER_WIDTH{1'b0}};

    assign axi.rvalid  = (state == ST_RD_DATA);
    assign axi.rid     = id_q;
    assign axi.rlast   = (state == ST_RD_DATA) && gen_last;
    assign axi.rresp   = (state == ST_RD_DATA && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.ruser   = {AXI_USER_WIDTH{1'b0}};
    assign axi.rdata   = (state == ST_RD_DATA && !err_q) ? (rd_first ? slave_rdata_i : rdata_q)
                                                         : '0;

endmodule

// File: tb/tb_tapasco_dm_axi_slave.sv
// tb/tb_tapasco_dm_axi_slave.sv - directed self-checking bench for tapasco_dm_axi_slave
module tb_tapasco_dm_axi_slave;
`ifdef TAPASCO_DM_AXI_BURST_EN
    localparam bit BEN = 1'b1;
`else
    localparam bit BEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req, we;
    logic [63:0] addr, wdata, rdata_in;
    logic [7:0]  be;
    int          total = 0;
    int          bad = 0;

    tapasco_dm_axi_slave_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .USER_W(4)) axi ();

    tapasco_dm_axi_slave dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .axi           (axi),
        .slave_req_o   (req),
        .slave_we_o    (we),
        .slave_addr_o  (addr),
        .slave_be_o    (be),
        .slave_wdata_o (wdata),
        .slave_rdata_i (rdata_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic v, input logic [3:0] id, input logic [63:0] a,
                          input logic [7:0] len, input logic [5:0] atop);
        axi.awvalid = v; axi.awid = id; axi.awaddr = a; axi.awlen = len;
        axi.awsize = 3'd3; axi.awburst = 2'b01; axi.awatop = atop;
    endtask

    task automatic set_ar(input logic v, input logic [3:0] id, input logic [63:0] a,
                          input logic [7:0] len, input logic [1:0] burst);
        axi.arvalid = v; axi.arid = id; axi.araddr = a; axi.arlen = len;
        axi.arsize = 3'd3; axi.arburst = burst;
    endtask

    task automatic set_w(input logic v, input logic [63:0] d, input logic [7:0] s, input logic l);
        axi.wvalid = v; axi.wdata = d; axi.wstrb = s; axi.wlast = l;
    endtask

    initial begin
        set_aw(0, 0, 0, 0, 0);
        set_ar(0, 0, 0, 0, 2'b01);
        set_w(0, 0, 0, 0);
        axi.bready = 0; axi.rready = 0; rdata_in = 0;
        step(); step();
        rst = 0;
        #1;
        chk("rst_awready", axi.awready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);

        // single write
        set_aw(1, 4'd3, 64'h800, 0, 0);
        #1 chk("wr_awready", axi.awready, 1);
        chk("wr_arready", axi.arready, 0);
        step();
        set_aw(0, 0, 0, 0, 0);
        set_w(1, 64'h1122334455667788, 8'hFF, 1);
        #1 chk("wr_wready", axi.wready, 1);
        chk("wr_req", req, 1);
        chk("wr_we", we, 1);
        chk("wr_addr", addr, 64'h800);
        chk("wr_be", be, 8'hFF);
        chk("wr_wdata", wdata, 64'h1122334455667788);
        step();
        set_w(0, 0, 0, 0);
        #1 chk("wr_bvalid", axi.bvalid, 1);
        chk("wr_bid", axi.bid, 3);
        chk("wr_bresp", axi.bresp, 2'b00);
        chk("wr_req_off", req, 0);
        axi.bready = 1;
        step();
        axi.bready = 0;
        #1 chk("wr_bvalid_off", axi.bvalid, 0);

        // single read
        set_ar(1, 4'd5, 64'h808, 0, 2'b01);
        #1 chk("rd_arready", axi.arready, 1);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        #1 chk("rd_req", req, 1);
        chk("rd_we", we, 0);
        chk("rd_addr", addr, 64'h808);
        chk("rd_be", be, 8'hFF);
        chk("rd_rvalid_early", axi.rvalid, 0);
        step();
        rdata_in = 64'hDEADBEEF;
        #1 chk("rd_rvalid", axi.rvalid, 1);
        chk("rd_rdata", axi.rdata, 64'hDEADBEEF);
        chk("rd_rlast", axi.rlast, 1);
        chk("rd_rresp", axi.rresp, 2'b00);
        chk("rd_rid", axi.rid, 5);
        axi.rready = 1;
        step();
        axi.rready = 0; rdata_in = 0;
        #1 chk("rd_rvalid_off", axi.rvalid, 0);

        // INCR read burst len=3 at 0x100
        set_ar(1, 4'd6, 64'h100, 8'd3, 2'b01);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            #1 chk("bu_req", req, BEN);
            if (BEN) chk("bu_addr", addr, 64'h100 + 64'(8 * i));
            step();
            rdata_in = 64'hA000 + 64'(i);
            #1 chk("bu_rvalid", axi.rvalid, 1);
            chk("bu_rresp", axi.rresp, BEN ? 2'b00 : 2'b10);
            chk("bu_rdata", axi.rdata, BEN ? 64'hA000 + 64'(i) : 64'h0);
            chk("bu_rlast", axi.rlast, i == 3);
            axi.rready = 1;
            step();
            axi.rready = 0; rdata_in = 0;
        end
        #1 chk("bu_done", axi.rvalid, 0);

        // WRAP read is an error
        set_ar(1, 4'd1, 64'h40, 0, 2'b10);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        #1 chk("wrap_req", req, 0);
        step();
        rdata_in = 64'h1234;
        #1 chk("wrap_rresp", axi.rresp, 2'b10);
        chk("wrap_rdata", axi.rdata, 0);
        chk("wrap_rlast", axi.rlast, 1);
        axi.rready = 1;
        step();
        axi.rready = 0; rdata_in = 0;

        // atomic write is an error, both beats drained
        set_aw(1, 4'd2, 64'h900, 8'd1, 6'h20);
        step();
        set_aw(0, 0, 0, 0, 0);
        set_w(1, 64'h1, 8'hFF, 0);
        #1 chk("atop_wready0", axi.wready, 1);
        chk("atop_req0", req, 0);
        step();
        set_w(1, 64'h2, 8'hFF, 1);
        #1 chk("atop_wready1", axi.wready, 1);
        chk("atop_req1", req, 0);
        step();
        set_w(0, 0, 0, 0);
        #1 chk("atop_bvalid", axi.bvalid, 1);
        chk("atop_bresp", axi.bresp, 2'b10);
        axi.bready = 1;
        step();
        axi.bready = 0;

        // tie after a write: read wins, then the held write
        set_aw(1, 4'd1, 64'h200, 0, 0);
        set_ar(1, 4'd2, 64'h300, 0, 2'b01);
        #1 chk("tie_arready", axi.arready, 1);
        chk("tie_awready", axi.awready, 0);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        #1 chk("tie_awready_busy", axi.awready, 0);
        chk("tie_rd_addr", addr, 64'h300);
        step();
        rdata_in = 64'hCAFE;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_rvalid", axi.rvalid, 1);
            chk("hold_rdata", axi.rdata, 64'hCAFE);
            chk("hold_rid", axi.rid, 2);
            step();
            rdata_in = 64'($urandom);
        end
        #1 chk("hold_rdata_end", axi.rdata, 64'hCAFE);
        axi.rready = 1;
        step();
        axi.rready = 0; rdata_in = 0;
        #1 chk("tie_awready2", axi.awready, 1);
        step();
        set_aw(0, 0, 0, 0, 0);
        set_w(1, 64'h77, 8'h0F, 1);
        #1 chk("tie_wr_req", req, 1);
        chk("tie_wr_addr", addr, 64'h200);
        chk("tie_wr_be", be, 8'h0F);
        step();
        set_w(0, 0, 0, 0);
        #1 chk("tie_bid", axi.bid, 1);
        axi.bready = 1;
        step();
        axi.bready = 0;

        // reset during the 2nd beat of a len=3 read
        set_ar(1, 4'd7, 64'h400, 8'd3, 2'b01);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        step();
        axi.rready = 1;
        step();
        axi.rready = 0;
        step();
        #1 chk("pre_rst_rvalid", axi.rvalid, 1);
        rst = 1;
        step();
        rst = 0;
        #1 chk("mid_rst_rvalid", axi.rvalid, 0);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_rid", axi.rid, 0);
        chk("mid_rst_wready", axi.wready, 0);
        set_ar(1, 4'd9, 64'hA8, 0, 2'b01);
        #1 chk("post_rst_arready", axi.arready, 1);
        step();
        set_ar(0, 0, 0, 0, 2'b01);
        #1 chk("post_rst_req", req, 1);
        chk("post_rst_addr", addr, 64'hA8);
        step();
        rdata_in = 64'h55;
        #1 chk("post_rst_rdata", axi.rdata, 64'h55);
        chk("post_rst_rid", axi.rid, 9);
        chk("post_rst_rresp", axi.rresp, 2'b00);
        axi.rready = 1;
        step();
        axi.rready = 0;
        #1 chk("post_rst_idle", axi.rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
